// File: rtl/jacobi_solver_pkg.sv
// Shared fixed-point format, derived widths, phase encoding and the
// fixed-point multiply used by the Jacobi solver and its reciprocal dividers.
package jacobi_pkg;

   localparam int FIX_PRECISION = 24;
   localparam int FIX_POINT     = 12;
   localparam int FIX_W         = FIX_PRECISION + FIX_POINT;
   localparam int FIX_R         = FIX_PRECISION + 2 * FIX_POINT - 1;

   typedef enum logic {
      PH_DIV,
      PH_ITER
   } phase_t;

   // Full-width product, floor-shifted back to the fixed point and wrapped to W bits.
   function automatic logic signed [FIX_W-1:0] fixmul(input logic signed [FIX_W-1:0] a,
                                                      input logic signed [FIX_W-1:0] c);
      logic signed [2*FIX_W-1:0] prod;
      prod = (2 * FIX_W)'(a) * (2 * FIX_W)'(c);
      return FIX_W'(prod >>> FIX_POINT);
   endfunction

endpackage

// File: rtl/jacobi_solver_recip_div.sv
// Bit-serial restoring divider producing trunc(2^(2*POINT) / |divisor|), one
// quotient bit per step, MSB first; the sign of the divisor is applied at the end.
module recip_div
   import jacobi_pkg::*;
#(
   parameter int W     = FIX_W,
   parameter int R     = FIX_R,
   parameter int POINT = FIX_POINT,
   parameter int CW    = $clog2(R + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                step,
   input  logic [CW-1:0]       count,
   input  logic signed [W-1:0] divisor,
   output logic signed [W-1:0] quotient,
   output logic                done
);

   // The only set dividend bit is 2^(2*POINT); it arrives on this step.
   localparam int ONE_STEP = R - 1 - 2 * POINT;

   logic [W-1:0] rem;
   logic [W-1:0] quo;
   logic [W-1:0] mag;
   logic [W-1:0] rem_next;
   logic [W-1:0] quo_next;
   logic [W:0]   shifted;
   logic [W:0]   diff;
   logic         dvd_bit;
   logic         fits;

   always_comb begin
      mag      = divisor[W-1] ? $unsigned(W'(-divisor)) : $unsigned(divisor);
      dvd_bit  = (count == CW'(ONE_STEP));
      shifted  = {rem, dvd_bit};
      diff     = shifted - {1'b0, mag};
      fits     = (shifted >= {1'b0, mag});
      rem_next = fits ? diff[W-1:0] : shifted[W-1:0];
      quo_next = {quo[W-2:0], fits};
      done     = step && (count == CW'(R - 1));
      // A zero diagonal would yield all-ones; force it to zero so that unknown stays 0.
      if (mag == '0) begin
         quotient = '0;
      end else if (divisor[W-1]) begin
         quotient = $signed(-quo_next);
      end else begin
         quotient = $signed(quo_next);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem <= '0;
         quo <= '0;
      end else if (step) begin
         rem <= rem_next;
         quo <= quo_next;
      end
   end

endmodule

// File: rtl/jacobi_solver.sv
// Fixed-point Jacobi solver: computes diagonal reciprocals serially after reset,
// then performs one full Jacobi iteration of A*x = b on every clock edge.
module jacobi_solver
   import jacobi_pkg::*;
#(
   parameter int  SIZE      = 3,
   parameter int  PRECISION = FIX_PRECISION,
   parameter int  POINT     = FIX_POINT,
   localparam int W         = PRECISION + POINT
) (
   input  logic                clk,
   input  logic                I_RSTn,
   input  logic signed [W-1:0] A [SIZE][SIZE],
   input  logic signed [W-1:0] b [SIZE],
   output logic signed [W-1:0] x [SIZE]
);

   localparam int R    = PRECISION + 2 * POINT - 1;
   localparam int CW   = $clog2(R + 1);
   localparam int ACCW = 2 * W + $clog2(SIZE) + 1;

   phase_t                phase;
   phase_t                phase_next;
   logic [CW-1:0]         count;
   logic                  div_step;
   logic [SIZE-1:0]       div_done;
   logic signed [W-1:0]   inv    [SIZE];
   logic signed [W-1:0]   quot   [SIZE];
   logic signed [W-1:0]   s      [SIZE];
   logic signed [W-1:0]   x_next [SIZE];
   logic signed [ACCW-1:0] acc   [SIZE];
   logic signed [2*W-1:0] prod;

   for (genvar gi = 0; gi < SIZE; gi++) begin : g_div
      recip_div #(
         .W     (W),
         .R     (R),
         .POINT (POINT),
         .CW    (CW)
      ) u_div (
         .clk      (clk),
         .rst_n    (I_RSTn),
         .step     (div_step),
         .count    (count),
         .divisor  (A[gi][gi]),
         .quotient (quot[gi]),
         .done     (div_done[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (!I_RSTn) begin
         phase <= PH_DIV;
      end else begin
         phase <= phase_next;
      end
   end

   // The divider phase lasts exactly R steps; ITER is terminal until reset.
   always_comb begin
      phase_next = phase;
      div_step   = 1'b0;
      unique case (phase)
         PH_DIV: begin
            div_step = 1'b1;
            if (count == CW'(R - 1)) begin
               phase_next = PH_ITER;
            end
         end
         PH_ITER: phase_next = PH_ITER;
      endcase
   end

   // Every row reads only the previous x, so all unknowns update together.
   always_comb begin
      prod = '0;
      for (int i = 0; i < SIZE; i++) begin
         acc[i] = '0;
         for (int j = 0; j < SIZE; j++) begin
            if (j != i) begin
               prod   = (2 * W)'(A[i][j]) * (2 * W)'(x[j]);
               acc[i] = acc[i] + ACCW'(prod);
            end
         end
         s[i]      = b[i] - W'(acc[i] >>> POINT);
         x_next[i] = fixmul(s[i], inv[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!I_RSTn) begin
         count <= '0;
         for (int i = 0; i < SIZE; i++) begin
            inv[i] <= '0;
            x[i]   <= '0;
         end
      end else begin
         if (div_step) begin
            count <= count + CW'(1);
         end
         for (int i = 0; i < SIZE; i++) begin
            if (div_done[i]) begin
               inv[i] <= quot[i];
            end
            if (phase == PH_ITER) begin
               x[i] <= x_next[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_jacobi_solver.sv
// Directed self-checking bench for jacobi_solver with hand-computed expectations.
module tb_jacobi_solver;

   localparam int SIZE  = 3;
   localparam int POINT = 12;
   localparam int W     = 36;
   localparam int R     = 47;

   logic                clk = 1'b0;
   logic                I_RSTn;
   logic signed [W-1:0] A [SIZE][SIZE];
   logic signed [W-1:0] b [SIZE];
   logic signed [W-1:0] x [SIZE];

   int am [SIZE][SIZE];
   int bv [SIZE];
   int checks   = 0;
   int failures = 0;

   jacobi_solver #(
      .SIZE      (SIZE),
      .PRECISION (24),
      .POINT     (POINT)
   ) dut (
      .clk    (clk),
      .I_RSTn (I_RSTn),
      .A      (A),
      .b      (b),
      .x      (x)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Loads am/bv as integers in Q12 and gives the DUT one reset edge.
   task automatic applyStimulus();
      @(negedge clk);
      for (int i = 0; i < SIZE; i++) begin
         for (int j = 0; j < SIZE; j++) begin
            A[i][j] = W'(longint'(am[i][j]) <<< POINT);
         end
         b[i] = W'(longint'(bv[i]) <<< POINT);
      end
      I_RSTn = 1'b0;
      @(negedge clk);
      I_RSTn = 1'b1;
   endtask

   task automatic runEdges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkRaw(input string tag, input longint e0, input longint e1, input longint e2);
      checkOutput({tag, "_x0"}, x[0], e0);
      checkOutput({tag, "_x1"}, x[1], e1);
      checkOutput({tag, "_x2"}, x[2], e2);
   endtask

   task automatic checkInt(input string tag, input longint e0, input longint e1, input longint e2);
      checkOutput({tag, "_x0"}, x[0] >>> POINT, e0);
      checkOutput({tag, "_x1"}, x[1] >>> POINT, e1);
      checkOutput({tag, "_x2"}, x[2] >>> POINT, e2);
   endtask

   initial begin
      I_RSTn = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         for (int j = 0; j < SIZE; j++) begin
            A[i][j] = '0;
         end
         b[i] = '0;
      end

      $display("[TB] tridiagonal system, b = [52,0,0]");
      am = '{'{3, -1, 0}, '{-1, 3, -1}, '{0, -1, 2}};
      bv = '{52, 0, 0};
      applyStimulus();
      checkRaw("reset", 0, 0, 0);
      for (int e = 1; e <= R; e++) begin
         runEdges(1);
         checkOutput($sformatf("div_hold_e%0d", e),
                     {63'd0, (x[0] == '0) && (x[1] == '0) && (x[2] == '0)}, 64'sd1);
      end
      runEdges(1);
      checkRaw("iter1", 70980, 0, 0);
      checkOutput("iter1_x0_int", x[0] >>> POINT, 17);
      runEdges(1);
      checkRaw("iter2", 70980, 23654, 0);
      runEdges(75 - 49);
      checkInt("conv", 19, 7, 3);

      $display("[TB] reset during iteration");
      applyStimulus();
      runEdges(60);
      applyStimulus();
      checkRaw("midreset", 0, 0, 0);
      runEdges(75);
      checkInt("reconv", 19, 7, 3);

      $display("[TB] negated right-hand side");
      bv = '{-52, 0, 0};
      applyStimulus();
      runEdges(75);
      checkInt("negconv", -20, -8, -4);

      $display("[TB] diagonal system with negative pivot");
      am = '{'{2, 0, 0}, '{0, 4, 0}, '{0, 0, -8}};
      bv = '{10, 8, 16};
      applyStimulus();
      runEdges(R);
      checkRaw("diag_div", 0, 0, 0);
      runEdges(1);
      checkRaw("diag_it1", 20480, 8192, -8192);
      runEdges(5);
      checkRaw("diag_it6", 20480, 8192, -8192);

      $display("[TB] zero pivot on row 1");
      am = '{'{2, 0, 0}, '{0, 0, 0}, '{0, 0, -8}};
      applyStimulus();
      runEdges(50);
      checkRaw("zpivot", 20480, 0, -8192);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
